// File: rtl/riscv_pkg.sv
// Shared fetch types for the RV32I front end: FSM states, FIFO entry layout
// and the instruction alignment helper.
package riscv_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int ALIGN_BITS  = $clog2(INSTR_BYTES);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [ALIGN_BITS-1:0] lsb);
        return lsb == '0;
    endfunction
endpackage

// File: rtl/ifetch_r32i_if.sv
// Instruction-memory request bus and decode handshake of the fetch unit.
// master = fetch unit, slave = memory + decode side.
interface ifetch_r32i_if #(parameter int dataW = 32);
    logic             MemReq;
    logic [dataW-1:0] MemAddr;
    logic             MemGnt;
    logic             MemRValid;
    logic [dataW-1:0] MemRData;
    logic             InstrValid;
    logic             InstrReady;
    logic [dataW-1:0] Instr;
    logic [dataW-1:0] InstrAddr;

    modport master (
        output MemReq, MemAddr, InstrValid, Instr, InstrAddr,
        input  MemGnt, MemRValid, MemRData, InstrReady
    );

    modport slave (
        input  MemReq, MemAddr, InstrValid, Instr, InstrAddr,
        output MemGnt, MemRValid, MemRData, InstrReady
    );
endinterface

// File: rtl/fetch_fifo_r32i.sv
// DEPTH-entry synchronous FIFO of fetch entries with registered storage;
// clear empties it on the next edge. Caller never pushes when full.
module fetch_fifo_r32i
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/ifetch_r32i.sv
// RV32I instruction fetch: one outstanding word read, FIFO-buffered responses.
// Optional IFETCH_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
//
// state | meaning
// IDLE  | may request FetchAddr when aligned, not flushing and FIFO has room
// WAIT  | request granted, awaiting MemRValid
// DROP  | flushed while in flight, next MemRValid is discarded
module ifetch_r32i
    import riscv_pkg::*;
#(
    parameter int dataW = 32,
    parameter int DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [dataW-1:0]  FetchAddr,
    output logic              AddrAccept,
    input  logic              Flush,
    output logic              MisalignErr,
    ifetch_r32i_if.master     bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [dataW-1:0]  PendAddr;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      wdata;
    logic              aligned;
    logic              mem_req;
    logic              rsp_take;
    logic              fifo_valid;
    logic              push;
    logic              pop;

    assign aligned    = is_aligned(FetchAddr[ALIGN_BITS-1:0]);
    assign fifo_valid = (count != '0);
    assign wdata      = '{addr: PendAddr, instr: bus.MemRData};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (mem_req && bus.MemGnt) state_nxt = WAIT;
            // a response landing with the flush is already dropped, so no DROP needed
            WAIT: if (bus.MemRValid)         state_nxt = IDLE;
                  else if (Flush)            state_nxt = DROP;
            DROP: if (bus.MemRValid)         state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        // reset gating keeps the combinational outputs quiet while reset is held
        mem_req        = (state == IDLE) && !reset && !Flush && aligned &&
                         (count < CW'(DEPTH));
        bus.MemReq     = mem_req;
        bus.MemAddr    = mem_req ? FetchAddr : '0;
        AddrAccept     = mem_req && bus.MemGnt;
        rsp_take       = (state == WAIT) && bus.MemRValid && !Flush;
        push           = rsp_take;
        pop            = fifo_valid && bus.InstrReady && !Flush;
        bus.InstrValid = fifo_valid;
        bus.Instr      = head.instr;
        bus.InstrAddr  = head.addr;
`ifdef IFETCH_BYPASS_EN
        if (!fifo_valid && rsp_take) begin
            bus.InstrValid = 1'b1;
            bus.Instr      = bus.MemRData;
            bus.InstrAddr  = PendAddr;
            push           = !bus.InstrReady;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PendAddr    <= '0;
            MisalignErr <= 1'b0;
        end else begin
            if (AddrAccept) PendAddr <= FetchAddr;
            if ((state == IDLE) && !Flush && !aligned) MisalignErr <= 1'b1;
        end
    end

    fetch_fifo_r32i #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (Flush),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );
endmodule
